fp16_mul_share_ctrl: RTL and testbench

//  Shares one free-running fp16 multiplier (no stall, no reset, fixed latency) among NREQ requesters.

---
 rtl/fp16_mul_share_ctrl.sv | 139 +++++++++++++
 tb/tb_fp16_mul_share_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_mul_share_ctrl.sv
// Shares one fixed-latency, free-running fp16 multiplier among NREQ requesters.
// Ops are issued round-robin with credit-based flow control into a fall-through response FIFO.
module fp16_mul_share_ctrl #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int MUL_LATENCY = 9,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [15:0]          mul_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + MUL_LATENCY + 1) + 1;
  localparam int EW = 16 + IDW;

  logic [IDW-1:0]         rr_ptr;
  logic [MUL_LATENCY-1:0] sh_vld;
  logic [IDW-1:0]         sh_id [MUL_LATENCY];
  logic [EW-1:0]          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          fifo_cnt;
  logic [CW-1:0]          inflight;
  logic                   have_credit;
  logic                   grant_vld;
  logic [IDW-1:0]         grant_id;
  logic                   push;
  logic                   pop;

  always_comb begin
    inflight = '0;
    for (int k = 0; k < MUL_LATENCY; k++) begin
      inflight = inflight + CW'(sh_vld[k]);
    end
  end

  assign have_credit = (fifo_cnt + inflight) < CW'(FIFO_DEPTH);

  // Two passes: indices below the pointer first, then those at/after it override,
  // so the lowest index at or after rr_ptr wins, wrapping otherwise.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    if (rst_n && have_credit) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req_valid[i] && (i < int'(rr_ptr))) begin
          grant_vld = 1'b1;
          grant_id  = IDW'(i);
        end
      end
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req_valid[i] && (i >= int'(rr_ptr))) begin
          grant_vld = 1'b1;
          grant_id  = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vld && (grant_id == IDW'(i))) begin
        req_ready[i] = 1'b1;
        mul_a        = req_a[16*i +: 16];
        mul_b        = req_b[16*i +: 16];
      end
    end
  end

  assign push      = sh_vld[MUL_LATENCY-1];
  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = fifo_mem[rd_ptr][15:0];
  assign rsp_id    = fifo_mem[rd_ptr][EW-1:16];
  assign busy      = (|sh_vld) | rsp_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      sh_vld   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (grant_vld) begin
        rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      end
      sh_vld <= {sh_vld[MUL_LATENCY-2:0], grant_vld};
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CW'(1);
      end else if (!push && pop) begin
        fifo_cnt <= fifo_cnt - CW'(1);
      end
    end
  end

  // Tag line and FIFO storage need no reset; the valid bits and pointers qualify them.
  always_ff @(posedge clk) begin
    sh_id[0] <= grant_id;
    for (int k = 1; k < MUL_LATENCY; k++) begin
      sh_id[k] <= sh_id[k-1];
    end
    if (push) begin
      fifo_mem[wr_ptr] <= {sh_id[MUL_LATENCY-1], mul_out};
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && (fifo_cnt == CW'(FIFO_DEPTH))))
        else $error("response fifo push while full");
    end
  end
`endif

endmodule

// File: tb/tb_fp16_mul_share_ctrl.sv
// Bench for fp16_mul_share_ctrl: fixed-latency multiplier model plus an in-order response scoreboard.
module tb_fp16_mul_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [15:0] mul_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int acc_cnt = 0;
  int last_acc_cyc = 0;
  int m_rr = 0;
  logic [15:0] exp_prod [4];
  logic [17:0] exp_q [$];
  logic [15:0] mpipe [9];

  fp16_mul_share_ctrl #(.NREQ(4), .IDW(2), .MUL_LATENCY(9), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Product table for the operand pairs this bench uses; anything else yields a marker value.
  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C00_4000: return 16'h4000;
      32'h4200_4400: return 16'h4A00;
      32'h4200_4200: return 16'h4880;
      32'h4400_4400: return 16'h4C00;
      32'h7C00_0000: return 16'h7E00;
      32'h7C00_C000: return 16'hFC00;
      32'h0001_3C00: return 16'h0001;
      default:       return 16'hBAD0;
    endcase
  endfunction

  always @(posedge clk) begin
    mpipe[0] <= fp_mul(mul_a, mul_b);
    for (int k = 1; k < 9; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_out = mpipe[8];

  function automatic int first_at(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  always @(negedge clk) begin
    int g;
    logic [17:0] e;
    if (!rst_n) begin
      exp_q.delete();
      m_rr = 0;
    end else begin
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      check("ready_wo_valid", 32'(req_ready & ~req_valid), 32'd0);
      if (req_ready != 4'b0) begin
        g = first_at(req_valid, m_rr);
        check("rr_grant", 32'(req_ready), 32'(4'b0001 << g));
        check("mul_ops", {mul_a, mul_b}, {req_a[16*g +: 16], req_b[16*g +: 16]});
        exp_q.push_back({2'(g), exp_prod[g]});
        m_rr = (g + 1) % 4;
        acc_cnt++;
        last_acc_cyc = cyc;
      end else begin
        check("mul_idle", {mul_a, mul_b}, 32'd0);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e[15:0]));
          check("rsp_id", 32'(rsp_id), 32'(e[17:16]));
        end
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    check({tag, "_sb"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic issue(input int id);
    @(posedge clk); #1;
    req_valid = 4'b0001 << id;
    @(posedge clk); #1;
    req_valid = 4'b0;
  endtask

  initial begin
    int t0;
    int acc0;
    int pop_cyc;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    req_a = {16'h4400, 16'h4200, 16'h4200, 16'h3C00};
    req_b = {16'h4400, 16'h4200, 16'h4400, 16'h4000};
    exp_prod[0] = 16'h4000;
    exp_prod[1] = 16'h4A00;
    exp_prod[2] = 16'h4880;
    exp_prod[3] = 16'h4C00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mul_ops", {mul_a, mul_b}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = 4'b0;

    // T1: single op latency
    @(posedge clk); #1;
    req_valid = 4'b0001;
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'd1);
    t0 = cyc;
    @(posedge clk); #1;
    req_valid = 4'b0;
    while (!rsp_valid && (cyc - t0) < 40) @(negedge clk);
    check("t1_latency", 32'(cyc - t0), 32'd10);
    wait_idle("t1_idle");

    // T2: all requesters every cycle, no bubbles
    @(posedge clk); #1;
    req_valid = 4'b1111;
    repeat (24) begin
      @(negedge clk);
      check("t2_nobubble", 32'(req_ready != 4'b0), 32'd1);
    end
    @(posedge clk); #1;
    req_valid = 4'b0;
    wait_idle("t2_idle");

    // T3: consumer stalled, credits cap accepts at FIFO depth
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    acc_cnt = 0;
    req_valid = 4'b0010;
    repeat (40) @(negedge clk);
    check("t3_accepts", 32'(acc_cnt), 32'd16);
    check("t3_ready_low", 32'(req_ready), 32'd0);
    check("t3_rsp_valid", 32'(rsp_valid), 32'd1);

    // T4: one pop frees exactly one credit, used the next cycle
    acc0 = acc_cnt;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    pop_cyc = cyc;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    repeat (15) @(negedge clk);
    check("t4_one_accept", 32'(acc_cnt - acc0), 32'd1);
    check("t4_accept_cycle", 32'(last_acc_cyc - pop_cyc), 32'd1);
    @(posedge clk); #1;
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    wait_idle("t4_idle");

    // T5: special values pass through with IDs preserved
    req_a[15:0]  = 16'h7C00; req_b[15:0]  = 16'h0000; exp_prod[0] = 16'h7E00;
    req_a[47:32] = 16'h7C00; req_b[47:32] = 16'hC000; exp_prod[2] = 16'hFC00;
    req_a[63:48] = 16'h0001; req_b[63:48] = 16'h3C00; exp_prod[3] = 16'h0001;
    issue(0);
    issue(2);
    issue(3);
    issue(1);
    wait_idle("t5_idle");

    // T6: reset with ops queued and in flight discards everything
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    repeat (3) @(posedge clk);
    #1 req_valid = 4'b0;
    repeat (12) @(posedge clk);
    #1 req_valid = 4'b0010;
    repeat (5) @(posedge clk);
    #1;
    req_valid = 4'b0;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_rr_zero", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 4'b0;
    repeat (20) @(negedge clk);
    wait_idle("t6_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
